// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory port, decode-side control and the IF/ID register outputs.
// The master modport is the fetch stage itself; slave is whoever drives memory and decode.
interface fetch_if;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic        stall_id;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc2;
  logic        ifid_valid;
  logic [15:0] pc;
  logic        halted;

  modport master (
    output imem_addr, imem_req, ifid_instr, ifid_pc2, ifid_valid, pc, halted,
    input  imem_rdata, imem_ready, stall_id, redirect, redirect_pc
  );

  modport slave (
    input  imem_addr, imem_req, ifid_instr, ifid_pc2, ifid_valid, pc, halted,
    output imem_rdata, imem_ready, stall_id, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with a one-entry skid buffer, halt detection on opcode 5'b00000
// and redirect flushing; feeds the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input logic clk,
  input logic rst,
  fetch_if.master bus
);

  typedef enum logic [1:0] {FETCH, SKID, HALTED} state_t;

  state_t      state, state_n;
  logic [15:0] pc_q, pc_n;
  logic [15:0] instr_q, instr_n;
  logic [15:0] pc2_q, pc2_n;
  logic        valid_q, valid_n;
  logic [15:0] skid_instr, skid_instr_n;
  logic [15:0] skid_pc2, skid_pc2_n;
  logic [15:0] pc_plus2;

  assign pc_plus2       = pc_q + 16'd2;
  assign bus.imem_addr  = pc_q;
  assign bus.imem_req   = (state == FETCH) && !rst;
  assign bus.pc         = pc_q;
  assign bus.ifid_instr = instr_q;
  assign bus.ifid_pc2   = pc2_q;
  assign bus.ifid_valid = valid_q;
  assign bus.halted     = (state == HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc2_q      <= 16'h0000;
      valid_q    <= 1'b0;
      skid_instr <= 16'h0000;
      skid_pc2   <= 16'h0000;
    end else begin
      state      <= state_n;
      pc_q       <= pc_n;
      instr_q    <= instr_n;
      pc2_q      <= pc2_n;
      valid_q    <= valid_n;
      skid_instr <= skid_instr_n;
      skid_pc2   <= skid_pc2_n;
    end
  end

  // Redirect outranks stall; an accepted word that decode cannot take goes to the skid, never re-read.
  always_comb begin
    state_n      = state;
    pc_n         = pc_q;
    instr_n      = instr_q;
    pc2_n        = pc2_q;
    valid_n      = valid_q;
    skid_instr_n = skid_instr;
    skid_pc2_n   = skid_pc2;

    if (bus.redirect) begin
      state_n      = FETCH;
      pc_n         = bus.redirect_pc;
      instr_n      = NOP_INSTR;
      valid_n      = 1'b0;
      skid_instr_n = 16'h0000;
      skid_pc2_n   = 16'h0000;
    end else begin
      case (state)
        FETCH: begin
          if (bus.imem_ready) begin
            pc_n = pc_plus2;
            if (!bus.stall_id) begin
              instr_n = bus.imem_rdata;
              pc2_n   = pc_plus2;
              valid_n = 1'b1;
              state_n = (bus.imem_rdata[15:11] == 5'b00000) ? HALTED : FETCH;
            end else begin
              skid_instr_n = bus.imem_rdata;
              skid_pc2_n   = pc_plus2;
              state_n      = SKID;
            end
          end else if (!bus.stall_id) begin
            instr_n = NOP_INSTR;
            valid_n = 1'b0;
          end
        end
        SKID: begin
          if (!bus.stall_id) begin
            instr_n = skid_instr;
            pc2_n   = skid_pc2;
            valid_n = 1'b1;
            state_n = (skid_instr[15:11] == 5'b00000) ? HALTED : FETCH;
          end
        end
        HALTED: begin
          if (!bus.stall_id) begin
            instr_n = NOP_INSTR;
            valid_n = 1'b0;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 16'h0800 (opcode 5'b00001): bubble instruction injected into IF/ID.
REQ-003 The block SHALL have one clock and synchronous, active-high reset. Ports are listed below as: name, direction, width, meaning.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous reset, active high.
REQ-006 imem_addr  out  16  instruction address; SHALL equal pc combinationally.
REQ-007 imem_req  out  1  fetch request; SHALL be 1 only in FETCH with rst=0.
REQ-008 imem_rdata  in  16  instruction word; valid only when imem_ready=1.
REQ-009 imem_ready  in  1  memory returns imem_rdata for imem_addr this cycle; 0 means memory busy.
REQ-010 stall_id  in  1  decode stalled; IF/ID SHALL hold.
REQ-011 redirect  in  1  taken branch/jump; flush and load redirect_pc.
REQ-012 redirect_pc  in  16  new PC, used when redirect=1.
REQ-013 ifid_instr  out  16  registered instruction to decode; the control decoder consumes ifid_instr[15:11].
REQ-014 ifid_pc2  out  16  registered PC+2 of ifid_instr.
REQ-015 ifid_valid  out  1  ifid_instr is a real instruction; 0 means bubble.
REQ-016 pc  out  16  current fetch PC.
REQ-017 halted  out  1  1 while the state is HALTED.

Function
REQ-018 States SHALL be FETCH, SKID and HALTED. The block SHALL have a 16-bit skid register skid_instr plus a skid_pc2 register.
REQ-019 Priority each cycle SHALL be: rst > redirect > stall_id > normal operation.
REQ-020 On redirect=1 from any state (including HALTED), the block SHALL:
- set pc to redirect_pc;
- set ifid_instr to NOP_INSTR and ifid_valid to 0;
- discard the skid contents;
- go to FETCH.
This applies regardless of stall_id. Halt is treated as speculative until redirect is known.
REQ-021 In FETCH with imem_ready=1 and stall_id=0:
- IF/ID SHALL load {imem_rdata, pc+2, valid=1};
- pc SHALL become pc+2;
- the next state SHALL be HALTED if imem_rdata[15:11]==5'b00000, else FETCH.
REQ-022 In FETCH with imem_ready=1 and stall_id=1:
- IF/ID SHALL hold;
- skid SHALL capture {imem_rdata, pc+2};
- pc SHALL become pc+2;
- the next state SHALL be SKID. Memory SHALL never be re-read for an accepted word.
REQ-023 In FETCH with imem_ready=0:
- pc SHALL hold;
- if stall_id=0, IF/ID SHALL load NOP_INSTR with valid=0;
- if stall_id=1, IF/ID SHALL hold.
REQ-024 In SKID, imem_req SHALL be 0. If stall_id=1, all state SHALL hold. If stall_id=0:
- IF/ID SHALL load {skid_instr, skid_pc2, 1};
- the next state SHALL be HALTED if skid_instr[15:11]==5'b00000, else FETCH.
REQ-025 In HALTED, imem_req SHALL be 0 and pc SHALL hold.
- If stall_id=0, IF/ID SHALL load NOP_INSTR with valid=0.
- The only exits SHALL be redirect or rst.
REQ-026 PC arithmetic SHALL be 16-bit modulo: 16'hFFFE+2 = 16'h0000, with no flag.
REQ-027 ifid_pc2 SHALL carry the same modulo value as the pc update.
REQ-028 At most one instruction SHALL be accepted from memory per cycle. At most one instruction SHALL be buffered (the skid).

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL set:
- pc=RESET_PC;
- ifid_instr=NOP_INSTR;
- ifid_pc2=16'h0000;
- ifid_valid=0;
- state=FETCH, halted=0;
- skid cleared.
REQ-030 rst asserted mid-SKID or mid-HALTED SHALL discard all in-flight instructions. No output SHALL depend on pre-reset state after that edge.
REQ-031 imem_req SHALL be 0 while rst=1.
REQ-032 The first request SHALL be in the first cycle after rst deasserts, at address RESET_PC.

Verification
REQ-033 Straight-line fetch:
- stimulus: release reset; imem_ready=1; words 16'h4021, 16'hD8A0, 16'h0800 at 0, 2, 4.
- response: ifid_instr takes each word on consecutive cycles; ifid_pc2 = 2, 4, 6; ifid_valid=1.
REQ-034 Stall with skid:
- stimulus: stall_id=1 for 3 cycles while memory returns 16'h4021 at pc=2.
- response: IF/ID holds; pc=4; imem_req=0 during the stall.
- on release: ifid_instr=16'h4021 with ifid_pc2=4; the next fetch is at address 4.
REQ-035 Memory busy:
- stimulus: imem_ready=0 for 2 cycles.
- response: pc holds; ifid_valid=0 with ifid_instr=16'h0800 for 2 cycles; fetch resumes at the same pc.
REQ-036 Halt:
- stimulus: fetch 16'h0000 at pc=6.
- response: ifid_instr=16'h0000 with valid=1; then halted=1, imem_req=0, pc=8 frozen; subsequent ifid_valid=0.
- stimulus: redirect=1 with redirect_pc=16'h0040.
- response: halted=0; the next fetch is at 16'h0040.
REQ-037 Redirect precedence:
- stimulus: redirect=1 and stall_id=1 in the same cycle while in SKID.
- response: skid discarded; pc=redirect_pc; ifid_valid=0.
REQ-038 Wrap-around and reset:
- stimulus: fetch at pc=16'hFFFE.
- response: ifid_pc2=16'h0000 and pc=16'h0000.
- stimulus: assert rst mid-HALTED.
- response: all outputs match REQ-029 on the next edge.
